store_range_sequencer: RTL and testbench
========================================

# store_range_sequencer

Sequencing controller for the heap-overflow range buffer used by the security checks in the execute stage. It watches the store stream issued alongside the branch unit, coalesces contiguous stores into address ranges, and ages out idle ranges. It commits ranges longer than a threshold to the external range buffer through a valid/ready write port, and answers load-in-range queries against its open and pending ranges.

## Interface
Parameters:
- ADDR_W, 32, address width.
- CNT_W, 16, width of the range length and statistics counters.
- MIN_LEN, 32, a range is committed only if its byte length is strictly greater than this.
- TIMEOUT, 10, number of non-store events tolerated before an open range closes (4-bit date, max 15).

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  drop the open range and any pending commit.
- st_valid_i  in  1  store event valid.
- st_ready_o  out  1  store event accepted when high with st_valid_i.
- st_addr_i  in  ADDR_W  store byte address.
- st_size_i  in  3  store size in bytes; 1, 2 and 4 are legal.
- ev_valid_i  in  1  one non-store instruction issued (ages the open range).
- ld_valid_i  in  1  load query valid.
- ld_addr_i  in  ADDR_W  load byte address.
- ld_hit_o  out  1  registered; load hit the open or pending range.
- wr_valid_o  out  1  committed range available for the range buffer.
- wr_ready_i  in  1  range buffer accepts the commit.
- wr_first_o  out  ADDR_W  first byte of the committed range.
- wr_last_o  out  ADDR_W  last byte of the committed range.
- active_o  out  1  a range is open (state TRACK).
- commit_cnt_o  out  CNT_W  completed write handshakes, saturating.
- drop_cnt_o  out  CNT_W  ranges closed with length <= MIN_LEN, saturating.

## Operation
- States: IDLE (no open range) and TRACK (range open). The pending commit is an independent flag driving wr_valid_o.
- Open-range registers: start, last (last byte), len (CNT_W, saturating), date (4 bits).
- Store acceptance: st_ready_o = ~wr_valid_o | wr_ready_i. An accepted store with an illegal size is consumed with no state change.
- IDLE with a legal store: go to TRACK with start=addr, last=addr+size-1, len=size, date=TIMEOUT.
- TRACK with a contiguous store (addr == last+1, compared in ADDR_W+1 bits so that wrap never matches): last=addr+size-1, len+=size, date=TIMEOUT.
- TRACK with a non-contiguous store: close the current range, then open a new range from this store in the same cycle. The state stays TRACK.
- TRACK with ev_valid_i and no accepted store:
  - If date != 0, decrement date.
  - If date == 0, close the range and go to IDLE.
- Store and ev_valid_i in the same cycle: the store wins and the event is ignored.
- Closing a range:
  - If len > MIN_LEN, load wr_first_o/wr_last_o and set wr_valid_o.
  - Otherwise increment drop_cnt_o.
- A store whose own bytes wrap past 2^ADDR_W-1 is treated as illegal.
- Write handshake: wr_valid_o, wr_first_o and wr_last_o are held stable until wr_valid_o & wr_ready_i. That cycle clears wr_valid_o and increments commit_cnt_o, unless a new commit loads in the same cycle, in which case wr_valid_o stays high with the new values.
- Load query: ld_hit_o(t+1) = ld_valid_i(t) & ((TRACK & start<=ld_addr<=last) | (wr_valid_o & wr_first_o<=ld_addr<=wr_last_o)), evaluated with the registers of cycle t.
- flush_i: go to IDLE and clear wr_valid_o, ld_hit_o, len and date. Counters are kept. Flush overrides a store, an event or a handshake in the same cycle; a store presented in that cycle is consumed and discarded.

## Timing
- Reset values:
  - state=IDLE, active_o=0, wr_valid_o=0, wr_first_o=0, wr_last_o=0, ld_hit_o=0, commit_cnt_o=0, drop_cnt_o=0.
  - st_ready_o=1.
- A store accepted at cycle t updates the range at t+1. A commit caused at t asserts wr_valid_o at t+1.
- st_ready_o is combinational from wr_valid_o and wr_ready_i. There is no other combinational path from inputs to outputs.
- Throughput is one store per cycle while no commit is stalled. While wr_valid_o=1 and wr_ready_i=0, stores are back-pressured and events still age the range.
- A timeout close while a commit is stalled holds the state in TRACK with date=0 until the port frees.
- Reset mid-handshake drops the pending commit.

## Test plan
- Contiguous run: SW to 0x1000..0x1020 (9 stores, len=36), then one store to 0x2000 -> wr_valid_o at the next cycle with first=0x1000, last=0x1023; new range start=0x2000; commit_cnt=1 after ready.
- Short run: 8 SW from 0x1000 (len=32), then 11 ev_valid_i -> closes on the 11th event, no wr_valid_o, drop_cnt=1, active_o=0.
- Back-pressure: commit pending with wr_ready_i=0 for 5 cycles -> st_ready_o=0 throughout, wr_first_o/wr_last_o stable; commit_cnt increments only on the ready cycle.
- Load query: open range 0x1000..0x1023; loads to 0x1023 and 0x1024 -> ld_hit_o=1 then 0, each one cycle after the query.
- Wrap and illegal sizes: SW at 0xFFFFFFFC, then SB at 0x00000000 -> new range, no merge; a store with size 3 -> no state change.
- Flush during a stalled commit with a simultaneous store -> IDLE, wr_valid_o=0, store discarded, counters unchanged.

Source files
------------

// File: rtl/store_range_sequencer.sv
// store_range_sequencer: coalesces contiguous stores into byte ranges, ages idle ranges,
// commits long ranges over a valid/ready port and answers load-in-range queries.
module store_range_sequencer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MIN_LEN = 32,
  parameter int unsigned TIMEOUT = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [2:0]        st_size_i,
  input  logic              ev_valid_i,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_hit_o,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_first_o,
  output logic [ADDR_W-1:0] wr_last_o,
  output logic              active_o,
  output logic [CNT_W-1:0]  commit_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);
  typedef enum logic {IDLE, TRACK} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] start_q, start_d, last_q, last_d, first_q, first_d, wlast_q, wlast_d;
  logic [CNT_W-1:0]  len_q, len_d, commit_q, commit_d, drop_q, drop_d;
  logic [3:0]        date_q, date_d;
  logic              wr_valid_q, wr_valid_d, ld_hit_q, ld_hit_d;
  logic              st_acc, legal, contig, hs, open_r, close_r, track;
  logic [ADDR_W:0]   end_sum;
  logic [CNT_W:0]    len_sum;
  logic [CNT_W-1:0]  len_inc;
  assign track      = state_q == TRACK;
  assign st_ready_o = ~wr_valid_q | wr_ready_i;
  assign st_acc     = st_valid_i & st_ready_o;
  assign hs         = wr_valid_q & wr_ready_i;
  // End address computed one bit wider so a store running past the top of memory is caught.
  assign end_sum    = {1'b0, st_addr_i} + (ADDR_W+1)'(st_size_i) - (ADDR_W+1)'(1);
  assign legal      = (st_size_i == 3'd1 || st_size_i == 3'd2 || st_size_i == 3'd4) & ~end_sum[ADDR_W];
  assign contig     = {1'b0, st_addr_i} == {1'b0, last_q} + (ADDR_W+1)'(1);
  assign len_sum    = {1'b0, len_q} + (CNT_W+1)'(st_size_i);
  assign len_inc    = len_sum[CNT_W] ? '1 : len_sum[CNT_W-1:0];
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    last_d     = last_q;
    len_d      = len_q;
    date_d     = date_q;
    wr_valid_d = wr_valid_q & ~wr_ready_i;
    first_d    = first_q;
    wlast_d    = wlast_q;
    commit_d   = hs && !(&commit_q) ? commit_q + CNT_W'(1) : commit_q;
    drop_d     = drop_q;
    open_r     = 1'b0;
    close_r    = 1'b0;
    if (st_acc && legal) begin
      if (track && contig) begin
        last_d = end_sum[ADDR_W-1:0];
        len_d  = len_inc;
        date_d = 4'(TIMEOUT);
      end else begin
        close_r = track;
        open_r  = 1'b1;
      end
    end else if (!st_acc && ev_valid_i && track) begin
      if (date_q != 4'd0) date_d = date_q - 4'd1;
      else if (st_ready_o) begin
        close_r = 1'b1;
        state_d = IDLE;
      end
    end
    if (open_r) begin
      state_d = TRACK;
      start_d = st_addr_i;
      last_d  = end_sum[ADDR_W-1:0];
      len_d   = CNT_W'(st_size_i);
      date_d  = 4'(TIMEOUT);
    end
    if (close_r && len_q > CNT_W'(MIN_LEN)) begin
      wr_valid_d = 1'b1;
      first_d    = start_q;
      wlast_d    = last_q;
    end else if (close_r && !(&drop_q)) drop_d = drop_q + CNT_W'(1);
    if (flush_i) begin
      state_d    = IDLE;
      wr_valid_d = 1'b0;
      len_d      = '0;
      date_d     = 4'd0;
      commit_d   = commit_q;
      drop_d     = drop_q;
    end
    ld_hit_d = ld_valid_i & ~flush_i &
               ((track & start_q <= ld_addr_i & ld_addr_i <= last_q) |
                (wr_valid_q & first_q <= ld_addr_i & ld_addr_i <= wlast_q));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      start_q    <= '0;
      last_q     <= '0;
      len_q      <= '0;
      date_q     <= 4'd0;
      wr_valid_q <= 1'b0;
      first_q    <= '0;
      wlast_q    <= '0;
      ld_hit_q   <= 1'b0;
      commit_q   <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      last_q     <= last_d;
      len_q      <= len_d;
      date_q     <= date_d;
      wr_valid_q <= wr_valid_d;
      first_q    <= first_d;
      wlast_q    <= wlast_d;
      ld_hit_q   <= ld_hit_d;
      commit_q   <= commit_d;
      drop_q     <= drop_d;
    end
  end
  assign ld_hit_o     = ld_hit_q;
  assign wr_valid_o   = wr_valid_q;
  assign wr_first_o   = first_q;
  assign wr_last_o    = wlast_q;
  assign active_o     = track;
  assign commit_cnt_o = commit_q;
  assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_store_range_sequencer.sv
// tb_store_range_sequencer: scoreboarded bench for store_range_sequencer.
module tb_store_range_sequencer;
  logic        clk = 0, rst = 1, flush = 0, st_valid = 0, ev_valid = 0, ld_valid = 0, wr_ready = 0;
  logic [31:0] st_addr = 0, ld_addr = 0;
  logic [2:0]  st_size = 0;
  logic        st_ready, ld_hit, wr_valid, active;
  logic [31:0] wr_first, wr_last;
  logic [15:0] commit_cnt, drop_cnt;
  int          errors = 0, checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got;
  always #5 clk = ~clk;
  store_range_sequencer dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .st_valid_i(st_valid), .st_ready_o(st_ready),
    .st_addr_i(st_addr), .st_size_i(st_size), .ev_valid_i(ev_valid), .ld_valid_i(ld_valid),
    .ld_addr_i(ld_addr), .ld_hit_o(ld_hit), .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
    .wr_first_o(wr_first), .wr_last_o(wr_last), .active_o(active),
    .commit_cnt_o(commit_cnt), .drop_cnt_o(drop_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && !flush && wr_valid && wr_ready) begin
      got = {wr_first, wr_last};
      if (exp_q.size() == 0) chk("unexpected_commit", got, 64'hx);
      else chk("commit_range", got, exp_q.pop_front());
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [2:0] s);
    st_valid = 1; st_addr = a; st_size = s;
    tick();
    st_valid = 0;
  endtask
  task automatic load(input logic [31:0] a, input logic exp, input string tag);
    ld_valid = 1; ld_addr = a;
    tick();
    ld_valid = 0;
    chk(tag, ld_hit, exp);
  endtask
  task automatic event_n(input int n);
    ev_valid = 1;
    repeat (n) tick();
    ev_valid = 0;
  endtask
  initial begin
    repeat (2) tick();
    rst = 0;
    chk("rst_active", active, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_first_last", {wr_first, wr_last}, 0);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_counters", {commit_cnt, drop_cnt}, 0);
    for (int i = 0; i < 9; i++) store(32'h1000 + 4 * i, 4);
    chk("run_active", active, 1);
    chk("run_no_commit", wr_valid, 0);
    exp_q.push_back({32'h1000, 32'h1023});
    store(32'h2000, 4);
    chk("commit_valid", wr_valid, 1);
    chk("commit_first", wr_first, 32'h1000);
    chk("commit_last", wr_last, 32'h1023);
    for (int i = 0; i < 5; i++) begin
      chk("bp_st_ready", st_ready, 0);
      chk("bp_stable", {wr_first, wr_last}, {32'h1000, 32'h1023});
      chk("bp_commit_cnt", commit_cnt, 0);
      if (i == 2) load(32'h1010, 1, "ld_pending_hit");
      else tick();
    end
    wr_ready = 1;
    tick();
    wr_ready = 0;
    chk("hs_commit_cnt", commit_cnt, 1);
    chk("hs_wr_valid", wr_valid, 0);
    load(32'h2003, 1, "ld_last_hit");
    load(32'h2004, 0, "ld_past_miss");
    load(32'h1fff, 0, "ld_before_miss");
    flush = 1;
    tick();
    flush = 0;
    chk("flush_idle", active, 0);
    for (int i = 0; i < 8; i++) store(32'h1000 + 4 * i, 4);
    event_n(10);
    chk("age_still_open", active, 1);
    event_n(1);
    chk("age_closed", active, 0);
    chk("short_drop", drop_cnt, 1);
    chk("short_no_commit", wr_valid, 0);
    store(32'hFFFF_FFFC, 4);
    store(32'h0000_0000, 1);
    chk("wrap_drop", drop_cnt, 2);
    chk("wrap_active", active, 1);
    store(32'h0000_0001, 3);
    store(32'hFFFF_FFFF, 2);
    chk("illegal_drop", drop_cnt, 2);
    load(32'h0, 1, "ld_new_range");
    load(32'h1, 0, "ld_illegal_no_merge");
    load(32'hFFFF_FFFF, 0, "ld_wrap_no_merge");
    for (int i = 0; i < 9; i++) store(32'h4000 + 4 * i, 4);
    store(32'h5000, 4);
    chk("drop_before_flush", drop_cnt, 3);
    chk("flush_pre_valid", wr_valid, 1);
    flush = 1; wr_ready = 1; st_valid = 1; st_addr = 32'h5004; st_size = 4;
    ld_valid = 1; ld_addr = 32'h4000;
    tick();
    flush = 0; wr_ready = 0; st_valid = 0; ld_valid = 0;
    chk("flush_active", active, 0);
    chk("flush_wr_valid", wr_valid, 0);
    chk("flush_ld_hit", ld_hit, 0);
    chk("flush_counters", {commit_cnt, drop_cnt}, {16'd1, 16'd3});
    load(32'h5004, 0, "flush_store_discarded");
    for (int i = 0; i < 9; i++) store(32'h6000 + 4 * i, 4);
    exp_q.push_back({32'h6000, 32'h6023});
    wr_ready = 1;
    event_n(11);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) tick();
    tick();
    wr_ready = 0;
    chk("timeout_commit_done", exp_q.size(), 0);
    chk("timeout_commit_cnt", commit_cnt, 2);
    chk("timeout_idle", active, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
